// File: rtl/sr_latch_bank.sv
// rtl/sr_latch_bank.sv - clocked bank of set/reset storage channels with conflict flags and edge pulses
module sr_latch_bank #(
    parameter int               WIDTH     = 8,
    parameter int               MODE      = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] conflict,
    output logic             any_err
);

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] conflict_next;

    // Outcome of a simultaneous set and reset on one channel, fixed by MODE
    function automatic logic resolve_both(input logic cur);
        case (MODE)
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return ~cur;
            default: return cur;
        endcase
    endfunction

    // Per-channel next value from the set/reset request pair
    always_comb begin
        q_next = q;
        for (int i = 0; i < WIDTH; i++) begin
            case ({s[i], r[i]})
                2'b10:   q_next[i] = 1'b1;
                2'b01:   q_next[i] = 1'b0;
                2'b11:   q_next[i] = resolve_both(q[i]);
                default: q_next[i] = q[i];
            endcase
        end
    end

    // Sticky conflict: clearing is independent of en, and a new conflict beats a clear
    always_comb begin
        conflict_next = (conflict & ~clr_err) | ({WIDTH{en}} & s & r);
    end

    // State register: q, edge pulses and conflict flags
    always_ff @(posedge clk) begin
        if (reset) begin
            q        <= RESET_VAL;
            rise     <= '0;
            fall     <= '0;
            conflict <= '0;
        end else begin
            conflict <= conflict_next;
            if (en) begin
                q    <= q_next;
                rise <= ~q & q_next;
                fall <= q & ~q_next;
            end else begin
                rise <= '0;
                fall <= '0;
            end
        end
    end

    assign q_n     = ~q;
    assign any_err = |conflict;

endmodule

// File: tb/tb_sr_latch_bank.sv
// tb/tb_sr_latch_bank.sv - table-driven scoreboard bench for sr_latch_bank across all four MODE values
module tb_sr_latch_bank;

    logic       clk;
    logic       reset;
    logic       en;
    logic [7:0] s;
    logic [7:0] r;
    logic [7:0] clr_err;

    logic [7:0] q_a        [4];
    logic [7:0] q_n_a      [4];
    logic [7:0] rise_a     [4];
    logic [7:0] fall_a     [4];
    logic [7:0] conflict_a [4];
    logic [3:0] any_err_a;

    typedef struct packed {
        logic            rst;
        logic            en;
        logic [7:0]      s;
        logic [7:0]      r;
        logic [7:0]      clr;
        logic [3:0][7:0] q;
        logic [7:0]      c;
    } vec_t;

    typedef struct packed {
        logic [3:0][7:0] q;
        logic [3:0][7:0] rise;
        logic [3:0][7:0] fall;
        logic [7:0]      c;
    } exp_t;

    exp_t            sb[$];
    logic [3:0][7:0] prev_q;
    int              n_checks;
    int              n_fail;
    vec_t            tbl[16];

    genvar g;
    for (g = 0; g < 4; g++) begin : g_dut
        sr_latch_bank #(
            .WIDTH(8),
            .MODE(g),
            .RESET_VAL(8'hA5)
        ) u_dut (
            .clk(clk),
            .reset(reset),
            .en(en),
            .s(s),
            .r(r),
            .clr_err(clr_err),
            .q(q_a[g]),
            .q_n(q_n_a[g]),
            .rise(rise_a[g]),
            .fall(fall_a[g]),
            .conflict(conflict_a[g]),
            .any_err(any_err_a[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int m, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s mode%0d got %h required %h at %0t", name, m, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue the expected post-edge outputs
    task automatic drive(input vec_t v);
        exp_t e;
        @(negedge clk);
        reset   = v.rst;
        en      = v.en;
        s       = v.s;
        r       = v.r;
        clr_err = v.clr;
        e.q = v.q;
        e.c = v.c;
        for (int m = 0; m < 4; m++) begin
            if (v.rst || !v.en) begin
                e.rise[m] = 8'h00;
                e.fall[m] = 8'h00;
            end else begin
                e.rise[m] = ~prev_q[m] & v.q[m];
                e.fall[m] = prev_q[m] & ~v.q[m];
            end
        end
        prev_q = v.q;
        sb.push_back(e);
    endtask

    function automatic vec_t mk(input logic rst, input logic en_v, input logic [7:0] sv, input logic [7:0] rv,
                                input logic [7:0] clr, input logic [7:0] q0, input logic [7:0] q1,
                                input logic [7:0] q2, input logic [7:0] q3, input logic [7:0] c);
        vec_t v;
        v.rst = rst;
        v.en  = en_v;
        v.s   = sv;
        v.r   = rv;
        v.clr = clr;
        v.q   = {q3, q2, q1, q0};
        v.c   = c;
        return v;
    endfunction

    // Output monitor: pops one expectation per clock once stimulus has been queued
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int m = 0; m < 4; m++) begin
                    check("q", m, q_a[m], e.q[m]);
                    check("q_n", m, q_n_a[m], ~e.q[m]);
                    check("rise", m, rise_a[m], e.rise[m]);
                    check("fall", m, fall_a[m], e.fall[m]);
                    check("conflict", m, conflict_a[m], e.c);
                    check("any_err", m, {7'd0, any_err_a[m]}, {7'd0, |e.c});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cnt;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        en       = 1'b0;
        s        = 8'h00;
        r        = 8'h00;
        clr_err  = 8'h00;
        prev_q   = {4{8'hA5}};

        //              rst  en  s      r      clr    q0     q1     q2     q3     conflict
        tbl[0]  = mk(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00);
        tbl[1]  = mk(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00);
        tbl[2]  = mk(1'b0, 1'b1, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        tbl[3]  = mk(1'b0, 1'b1, 8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00);
        tbl[4]  = mk(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00);
        tbl[5]  = mk(1'b0, 1'b1, 8'h01, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01);
        tbl[6]  = mk(1'b0, 1'b1, 8'h01, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 8'h01);
        tbl[7]  = mk(1'b0, 1'b1, 8'h01, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01);
        tbl[8]  = mk(1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01);
        tbl[9]  = mk(1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01);
        tbl[10] = mk(1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00);
        tbl[11] = mk(1'b0, 1'b1, 8'h80, 8'h80, 8'h00, 8'hFF, 8'hFF, 8'h7F, 8'h7F, 8'h80);
        tbl[12] = mk(1'b0, 1'b0, 8'h01, 8'h01, 8'h81, 8'hFF, 8'hFF, 8'h7F, 8'h7F, 8'h00);
        tbl[13] = mk(1'b0, 1'b1, 8'h01, 8'h01, 8'h01, 8'hFF, 8'hFF, 8'h7E, 8'h7E, 8'h01);
        tbl[14] = mk(1'b0, 1'b1, 8'h0F, 8'hF0, 8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h01);
        tbl[15] = mk(1'b0, 1'b1, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i]);
        end

        // All channels in conflict, then reset lands mid-toggle and aborts pulses
        drive(mk(1'b0, 1'b1, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF));
        drive(mk(1'b1, 1'b1, 8'hFF, 8'hFF, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00));
        drive(mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00));

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
